// File: rtl/ov7670_cfg_pkg.sv
// ov7670_cfg_pkg: shared states, table markers and SCCB direction codes for the OV7670 config sequencer
package ov7670_cfg_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RST_HOLD,
        S_PWR_WAIT,
        S_FETCH,
        S_DECODE,
        S_WRITE,
        S_WRITE_WAIT,
        S_VERIFY,
        S_VERIFY_WAIT,
        S_DELAY,
        S_DONE,
        S_ERROR
    } state_e;

    localparam logic [15:0] END_MARKER = 16'hFFFF;
    localparam logic [7:0]  DELAY_ADDR = 8'hFF;
    localparam logic        SCCB_WR    = 1'b0;
    localparam logic        SCCB_RD    = 1'b1;

    function automatic logic is_timed(input state_e s);
        return (s == S_RST_HOLD) || (s == S_PWR_WAIT) || (s == S_DELAY);
    endfunction

endpackage

// File: rtl/ov7670_ms_timer.sv
// ov7670_ms_timer: millisecond tick generator with an 8-bit elapsed-ms count, restarted by clear
module ov7670_ms_timer #(
    parameter int INPUT_CLK_FREQ = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    output logic       tick,
    output logic [7:0] ms_count
);

    localparam int PERIOD = (INPUT_CLK_FREQ / 1000 > 1) ? INPUT_CLK_FREQ / 1000 : 2;
    localparam int CW = $clog2(PERIOD);
    localparam logic [CW-1:0] CYC_ONE = 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(PERIOD - 1);

    logic [CW-1:0] cyc_q, cyc_d;
    logic [7:0]    ms_q, ms_d;

    assign tick = cyc_q == CYC_LAST;
    assign ms_count = ms_q;

    // next cycle/ms counts: clear wins, otherwise wrap the cycle counter on each tick
    always_comb begin
        cyc_d = clear ? '0 : tick ? '0 : cyc_q + CYC_ONE;
        ms_d  = clear ? '0 : tick ? ms_q + 8'd1 : ms_q;
    end

    // counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc_q <= '0;
            ms_q  <= '0;
        end else begin
            cyc_q <= cyc_d;
            ms_q  <= ms_d;
        end
    end

endmodule

// File: rtl/ov7670_config_sequencer.sv
// ov7670_config_sequencer: camera power-up then ROM-driven SCCB register writes with retry;
// define SCCB_READBACK_VERIFY_EN to read each acked write back and retry on mismatch
module ov7670_config_sequencer
    import ov7670_cfg_pkg::*;
#(
    parameter int INPUT_CLK_FREQ  = 25000000,
    parameter int ROM_AW          = 8,
    parameter int MAX_RETRY       = 3,
    parameter int RESET_HOLD_MS   = 1,
    parameter int POWERUP_WAIT_MS = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic              sccb_req,
    output logic              sccb_rw,
    output logic [7:0]        sccb_sub_address,
    output logic [7:0]        sccb_set_data,
    input  logic              sccb_done,
    input  logic              sccb_nack,
    input  logic [7:0]        sccb_rd_data,
    output logic              ov7670_pwdn,
    output logic              ov7670_reset,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ROM_AW-1:0] err_index,
    output logic [ROM_AW:0]   write_count
);

    localparam logic [ROM_AW-1:0] ADDR_ONE = 1;
    localparam logic [ROM_AW:0]   WC_ONE   = 1;
    localparam logic [3:0]        RETRY_MAX = 4'(MAX_RETRY);
    localparam logic [7:0]        HOLD_LAST = 8'(RESET_HOLD_MS - 1);
    localparam logic [7:0]        WAIT_LAST = 8'(POWERUP_WAIT_MS - 1);

    state_e            state_q, state_d;
    logic [ROM_AW-1:0] rom_addr_q, rom_addr_d, err_q, err_d;
    logic [ROM_AW:0]   wc_q, wc_d;
    logic [3:0]        retry_q, retry_d;
    logic [7:0]        sub_q, sub_d, set_q, set_d, dly_q, dly_d;
    logic              done_q, done_d, error_q, error_d, busy_q, busy_d;
    logic              ovr_q, ovr_d, req_q, req_d;
    logic              adv, wr_ok, fail, fin;
    logic              tick, tmr_clear;
    logic [7:0]        ms_count;

    assign tmr_clear = (state_d != state_q) || !is_timed(state_q);

    ov7670_ms_timer #(.INPUT_CLK_FREQ(INPUT_CLK_FREQ)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (tmr_clear),
        .tick     (tick),
        .ms_count (ms_count)
    );

`ifdef SCCB_READBACK_VERIFY_EN
    logic rw_q, rw_d;
    assign sccb_rw = rw_q;
`else
    logic unused_rd;
    assign unused_rd = ^sccb_rd_data;
    assign sccb_rw = SCCB_WR;
`endif

    // sequencer next state: per-state actions raise adv/fail/fin, resolved after the case
    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        err_d      = err_q;
        wc_d       = wc_q;
        retry_d    = retry_q;
        sub_d      = sub_q;
        set_d      = set_q;
        dly_d      = dly_q;
        done_d     = done_q;
        error_d    = error_q;
        busy_d     = busy_q;
        ovr_d      = ovr_q;
        req_d      = 1'b0;
`ifdef SCCB_READBACK_VERIFY_EN
        rw_d       = rw_q;
`endif
        adv        = 1'b0;
        wr_ok      = 1'b0;
        fail       = 1'b0;
        fin        = 1'b0;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: if (start) begin
                state_d    = S_RST_HOLD;
                rom_addr_d = '0;
                wc_d       = '0;
                retry_d    = '0;
                done_d     = 1'b0;
                error_d    = 1'b0;
                ovr_d      = 1'b0;
                busy_d     = 1'b1;
            end
            S_RST_HOLD: if (tick && ms_count == HOLD_LAST) begin
                ovr_d   = 1'b1;
                state_d = S_PWR_WAIT;
            end
            S_PWR_WAIT: if (tick && ms_count == WAIT_LAST) state_d = S_FETCH;
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                if (rom_data == END_MARKER) fin = 1'b1;
                else if (rom_data[15:8] == DELAY_ADDR) begin
                    if (rom_data[7:0] == 8'd0) adv = 1'b1;
                    else begin
                        dly_d   = rom_data[7:0];
                        state_d = S_DELAY;
                    end
                end else begin
                    sub_d   = rom_data[15:8];
                    set_d   = rom_data[7:0];
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                req_d   = 1'b1;
`ifdef SCCB_READBACK_VERIFY_EN
                rw_d    = SCCB_WR;
`endif
                state_d = S_WRITE_WAIT;
            end
            S_WRITE_WAIT: if (sccb_done) begin
                if (sccb_nack) fail = 1'b1;
`ifdef SCCB_READBACK_VERIFY_EN
                else state_d = S_VERIFY;
`else
                else begin
                    adv   = 1'b1;
                    wr_ok = 1'b1;
                end
`endif
            end
`ifdef SCCB_READBACK_VERIFY_EN
            S_VERIFY: begin
                req_d   = 1'b1;
                rw_d    = SCCB_RD;
                state_d = S_VERIFY_WAIT;
            end
            S_VERIFY_WAIT: if (sccb_done) begin
                if (sccb_nack || sccb_rd_data != set_q) fail = 1'b1;
                else begin
                    adv   = 1'b1;
                    wr_ok = 1'b1;
                end
            end
`endif
            S_DELAY: if (tick && ms_count == dly_q - 8'd1) adv = 1'b1;
            default: state_d = S_IDLE;
        endcase
        if (fail) begin
            if (retry_q < RETRY_MAX) begin
                retry_d = retry_q + 4'd1;
                state_d = S_WRITE;
            end else begin
                state_d = S_ERROR;
                err_d   = rom_addr_q;
                error_d = 1'b1;
                busy_d  = 1'b0;
            end
        end
        if (adv) begin
            retry_d = '0;
            wc_d    = wr_ok ? wc_q + WC_ONE : wc_q;
            if (&rom_addr_q) fin = 1'b1;
            else begin
                rom_addr_d = rom_addr_q + ADDR_ONE;
                state_d    = S_FETCH;
            end
        end
        if (fin) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
        end
    end

    // state and output registers; camera reset idles released (high)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            rom_addr_q <= '0;
            err_q      <= '0;
            wc_q       <= '0;
            retry_q    <= '0;
            sub_q      <= '0;
            set_q      <= '0;
            dly_q      <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            busy_q     <= 1'b0;
            ovr_q      <= 1'b1;
            req_q      <= 1'b0;
`ifdef SCCB_READBACK_VERIFY_EN
            rw_q       <= SCCB_WR;
`endif
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            err_q      <= err_d;
            wc_q       <= wc_d;
            retry_q    <= retry_d;
            sub_q      <= sub_d;
            set_q      <= set_d;
            dly_q      <= dly_d;
            done_q     <= done_d;
            error_q    <= error_d;
            busy_q     <= busy_d;
            ovr_q      <= ovr_d;
            req_q      <= req_d;
`ifdef SCCB_READBACK_VERIFY_EN
            rw_q       <= rw_d;
`endif
        end
    end

    assign rom_addr         = rom_addr_q;
    assign sccb_req         = req_q;
    assign sccb_sub_address = sub_q;
    assign sccb_set_data    = set_q;
    assign ov7670_pwdn      = 1'b0;
    assign ov7670_reset     = ovr_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign error            = error_q;
    assign err_index        = err_q;
    assign write_count      = wc_q;

endmodule

// File: tb/tb_ov7670_config_sequencer.sv
// tb_ov7670_config_sequencer: scoreboard bench with a ROM model and an SCCB slave model (ack after 20 cycles)
module tb_ov7670_config_sequencer;

    typedef struct packed {
        logic       rw;
        logic [7:0] sub;
        logic [7:0] dat;
    } txn_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  rom_addr;
    logic [15:0] rom_data = '0;
    logic        sccb_req, sccb_rw;
    logic [7:0]  sccb_sub_address, sccb_set_data;
    logic        sccb_done = 1'b0, sccb_nack = 1'b0;
    logic [7:0]  sccb_rd_data = '0;
    logic        ov7670_pwdn, ov7670_reset, busy, done, error;
    logic [1:0]  err_index;
    logic [2:0]  write_count;

    logic [15:0] rom [4];
    logic [7:0]  mem [256];
    logic [7:0]  nack_sub = 8'h00, nack_left = 8'd0;
    logic [7:0]  bad_sub = 8'h00, bad_left = 8'd0;
    txn_t        exp_q[$];
    int          wr_cyc[$];
    int          cyc = 0, total = 0, bad = 0;
    int          fall_cyc = 0, rise_cyc = 0;
    logic        last_ovr = 1'b1;

`ifdef SCCB_READBACK_VERIFY_EN
    localparam int GAP = 5048;
`else
    localparam int GAP = 5026;
`endif

    ov7670_config_sequencer #(
        .INPUT_CLK_FREQ(1000000), .ROM_AW(2), .MAX_RETRY(3),
        .RESET_HOLD_MS(1), .POWERUP_WAIT_MS(10)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
        .sccb_req(sccb_req), .sccb_rw(sccb_rw), .sccb_sub_address(sccb_sub_address),
        .sccb_set_data(sccb_set_data), .sccb_done(sccb_done), .sccb_nack(sccb_nack),
        .sccb_rd_data(sccb_rd_data), .ov7670_pwdn(ov7670_pwdn), .ov7670_reset(ov7670_reset),
        .busy(busy), .done(done), .error(error), .err_index(err_index), .write_count(write_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_w(input logic [7:0] s, input logic [7:0] d);
        exp_q.push_back({1'b0, s, d});
    endtask

    // write that the DUT will follow with a readback when verification is built in
    task automatic push_wv(input logic [7:0] s, input logic [7:0] d);
        push_w(s, d);
`ifdef SCCB_READBACK_VERIFY_EN
        exp_q.push_back({1'b1, s, d});
`endif
    endtask

    task automatic set_rom(input logic [15:0] a, b, c, d);
        rom[0] = a; rom[1] = b; rom[2] = c; rom[3] = d;
    endtask

    // monitor: every request is popped against the scoreboard; also timestamps reset edges
    always @(negedge clk) begin
        if (reset && sccb_req) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL sb_unexpected: got %h expected none", {sccb_rw, sccb_sub_address, sccb_set_data});
            end else begin
                txn_t e;
                e = exp_q.pop_front();
                total++;
                if ({sccb_rw, sccb_sub_address, sccb_set_data} != e) begin
                    bad++;
                    $display("FAIL sb_txn: got %h expected %h", {sccb_rw, sccb_sub_address, sccb_set_data}, e);
                end
            end
            if (!sccb_rw) wr_cyc.push_back(cyc);
        end
        if (ov7670_reset != last_ovr) begin
            if (ov7670_reset) rise_cyc = cyc; else fall_cyc = cyc;
            last_ovr = ov7670_reset;
        end
    end

    // SCCB slave model: completes each request 20 cycles later, abandoning it on reset
    initial begin
        logic       rw, ab;
        logic [7:0] s, d;
        forever begin
            @(posedge clk); #1;
            if (reset && sccb_req) begin
                rw = sccb_rw; s = sccb_sub_address; d = sccb_set_data; ab = 1'b0;
                for (int i = 0; i < 20; i++) begin
                    @(posedge clk);
                    if (!reset) ab = 1'b1;
                end
                #1;
                if (!ab && reset) begin
                    sccb_nack = 1'b0;
                    if (!rw) begin
                        if (s == nack_sub && nack_left != 0) begin
                            sccb_nack = 1'b1;
                            if (nack_left != 8'hFF) nack_left--;
                        end else mem[s] = d;
                    end else if (s == bad_sub && bad_left != 0) begin
                        sccb_rd_data = 8'h7F;
                        bad_left--;
                    end else sccb_rd_data = mem[s];
                    sccb_done = 1'b1;
                    @(posedge clk); #1;
                    sccb_done = 1'b0;
                    sccb_nack = 1'b0;
                end
            end
        end
    end

    task automatic run_and_wait();
        int n;
        wr_cyc.delete();
        @(negedge clk) start = 1'b1;
        @(negedge clk) chk("busy_rise", busy, 1);
        repeat (3) @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(done || error) && n < 40000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40000) begin
            total++; bad++;
            $display("FAIL run_timeout: got no done/error expected one within 40000 cycles");
        end
        chk("done_err_excl", int'(done & error), 0);
    endtask

    initial begin
        int n;
        set_rom(16'h1280, 16'hFF05, 16'h1101, 16'hFFFF);
        repeat (3) @(negedge clk);
        chk("rst_ov_reset", ov7670_reset, 1);
        chk("rst_busy_done_err", {busy, done, error}, 0);
        chk("rst_req_rw", {sccb_req, sccb_rw, ov7670_pwdn}, 0);
        chk("rst_sub_data", {sccb_sub_address, sccb_set_data}, 0);
        chk("rst_addr_idx_wc", {rom_addr, err_index, write_count}, 0);
        reset = 1'b1;

        // power-up timing, delay entry and end marker
        push_wv(8'h12, 8'h80); push_wv(8'h11, 8'h01);
        run_and_wait();
        chk("t1_done", done, 1);
        chk("t1_error", error, 0);
        chk("t1_busy", busy, 0);
        chk("t1_wc", write_count, 2);
        chk("t1_reset_low", rise_cyc - fall_cyc, 1000);
        chk("t1_nwrites", wr_cyc.size(), 2);
        if (wr_cyc.size() == 2) begin
            chk("t1_first_req", wr_cyc[0] - rise_cyc, 10003);
            chk("t1_gap", wr_cyc[1] - wr_cyc[0], GAP);
        end
        chk("t1_sb_empty", exp_q.size(), 0);

        // reset during WRITE_WAIT
        push_wv(8'h12, 8'h80);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 0;
        while (!sccb_req && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("t2_req_seen", int'(sccb_req), 1);
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("t2_async_ovr", ov7670_reset, 1);
        chk("t2_async_flags", {busy, done, error, sccb_req, sccb_rw}, 0);
        chk("t2_async_regs", {rom_addr, write_count, sccb_sub_address, sccb_set_data}, 0);
        exp_q.delete();
        @(negedge clk) reset = 1'b1;

        // rerun from entry 0 with two NACKs on 0x11
        set_rom(16'h1280, 16'h1101, 16'hFFFF, 16'hFFFF);
        nack_sub = 8'h11; nack_left = 8'd2;
        push_wv(8'h12, 8'h80); push_w(8'h11, 8'h01); push_w(8'h11, 8'h01); push_wv(8'h11, 8'h01);
        run_and_wait();
        chk("t3_done", done, 1);
        chk("t3_error", error, 0);
        chk("t3_wc", write_count, 2);
        chk("t3_sb_empty", exp_q.size(), 0);

        // permanent NACK on 0x11 at index 2, zero-length delay at index 1
        set_rom(16'h1280, 16'hFF00, 16'h1101, 16'hFFFF);
        nack_left = 8'hFF;
        push_wv(8'h12, 8'h80);
        for (int i = 0; i < 4; i++) push_w(8'h11, 8'h01);
        run_and_wait();
        chk("t4_error", error, 1);
        chk("t4_done", done, 0);
        chk("t4_busy", busy, 0);
        chk("t4_err_index", err_index, 2);
        chk("t4_wc", write_count, 1);
        chk("t4_sb_empty", exp_q.size(), 0);
        nack_left = 8'd0;

        // table without end marker ends after the last entry
        set_rom(16'h1280, 16'h1101, 16'h1302, 16'h1403);
        push_wv(8'h12, 8'h80); push_wv(8'h11, 8'h01); push_wv(8'h13, 8'h02); push_wv(8'h14, 8'h03);
        run_and_wait();
        chk("t5_done", done, 1);
        chk("t5_error", error, 0);
        chk("t5_wc", write_count, 4);
        chk("t5_addr_nowrap", rom_addr, 3);
        chk("t5_sb_empty", exp_q.size(), 0);

`ifdef SCCB_READBACK_VERIFY_EN
        // first readback of 0x12 mismatches, second matches
        set_rom(16'h1280, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        bad_sub = 8'h12; bad_left = 8'd1;
        push_wv(8'h12, 8'h80); push_wv(8'h12, 8'h80);
        run_and_wait();
        chk("t6_done", done, 1);
        chk("t6_wc", write_count, 1);
        chk("t6_sb_empty", exp_q.size(), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
